// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter: default geometry,
// FSM encoding, requester indices and the two-way round-robin pick.
package ram_arbiter_pkg;

  localparam int ARB_ADDR_W = 8;
  localparam int ARB_DATA_W = 12;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // One-hot grant {g1, g0}; on a tie the requester that was not served last wins.
  function automatic logic [1:0] rr_grant2(input logic v0, input logic v1, input logic last);
    logic [1:0] g;
    g = 2'b00;
    if (v0 && v1) g = (last == REQ0) ? 2'b10 : 2'b01;
    else if (v0)  g = 2'b01;
    else if (v1)  g = 2'b10;
    return g;
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Front end for one single-port RAM: zero-fills it after reset, then shares it
// between two requesters with round-robin arbitration and registered read responses.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int               ADDR_W   = ARB_ADDR_W,
  parameter int               DATA_W   = ARB_DATA_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,

  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,

  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,

  output logic              init_done
);

  arb_state_t        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_last_grant;
  logic [1:0]        w_grant;

  // Grants are only issued in RUN and never while reset is asserted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_grant = 2'b00;
    if (rst_n && r_state == ST_RUN)
      w_grant = rr_grant2(req0_valid, req1_valid, r_last_grant);
  end

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];

  always_comb begin
    ram_addr = req0_addr;
    ram_din  = req0_wdata;
    ram_we   = 1'b0;
    if (r_state == ST_INIT) begin
      ram_addr = r_cnt;
      ram_din  = INIT_VAL;
      ram_we   = rst_n;
    end else if (w_grant[1]) begin
      ram_addr = req1_addr;
      ram_din  = req1_wdata;
      ram_we   = req1_we;
    end else if (w_grant[0]) begin
      ram_we   = req0_we;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_state      <= ST_INIT;
      r_cnt        <= '0;
      r_last_grant <= REQ1;
      init_done    <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp0_data    <= '0;
      rsp1_valid   <= 1'b0;
      rsp1_data    <= '0;
    end else begin
      rsp0_valid <= w_grant[0] && !req0_we;
      rsp1_valid <= w_grant[1] && !req1_we;
      if (w_grant[0] && !req0_we) rsp0_data <= ram_dout;
      if (w_grant[1] && !req1_we) rsp1_data <= ram_dout;

      if (r_state == ST_INIT) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == '1) begin
          r_state   <= ST_RUN;
          init_done <= 1'b1;
        end
      end else if (|w_grant) begin
        r_last_grant <= w_grant[1] ? REQ1 : REQ0;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM wired as a sibling.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int AW = ARB_ADDR_W;
  localparam int DW = ARB_DATA_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_we, req1_valid, req1_we;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_data, rsp1_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          ram_we, init_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .init_done(init_done)
  );

  // Behavioural RAM: synchronous write, asynchronous read, preloaded non-zero.
  logic [DW-1:0] mem [2**AW];
  initial for (int i = 0; i < 2**AW; i++) mem[i] = 12'hFFF;
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
  assign ram_dout = mem[ram_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          v0, we0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1, we1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          e_rdy0, e_rdy1, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic          e_rv0;
    logic [DW-1:0] e_rd0;
    logic          e_rv1;
    logic [DW-1:0] e_rd1;
  } vec_t;

  task automatic drive(input logic v0, input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    drive(v.v0, v.we0, v.a0, v.d0, v.v1, v.we1, v.a1, v.d1);
    #1;
    check($sformatf("v%0d_ready", idx), {req1_ready, req0_ready}, {v.e_rdy1, v.e_rdy0});
    check($sformatf("v%0d_ram_we", idx), ram_we, v.e_we);
    if (v.e_rdy0 || v.e_rdy1) check($sformatf("v%0d_ram_addr", idx), ram_addr, v.e_addr);
    if (v.e_we) check($sformatf("v%0d_ram_din", idx), ram_din, v.e_din);
    @(posedge clk);
    #1;
    check($sformatf("v%0d_rsp_valid", idx), {rsp1_valid, rsp0_valid}, {v.e_rv1, v.e_rv0});
    if (v.e_rv0) check($sformatf("v%0d_rsp0_data", idx), rsp0_data, v.e_rd0);
    if (v.e_rv1) check($sformatf("v%0d_rsp1_data", idx), rsp1_data, v.e_rd1);
  endtask

  // Releases reset on a negedge, checks all 2^AW fill cycles, then the first RUN cycle.
  task automatic run_init(input logic exp_rdy0_run);
    rst_n = 1'b1;
    for (int i = 0; i < 2**AW; i++) begin
      #1;
      check($sformatf("init_c%0d", i), {init_done, ram_we, req0_ready, ram_addr, ram_din},
            {1'b0, 1'b1, 1'b0, AW'(i), {DW{1'b0}}});
      @(negedge clk);
    end
    #1;
    check("init_done_run", init_done, 1'b1);
    check("first_run_ready0", req0_ready, exp_rdy0_run);
  endtask

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{1,1,8'h10,12'hABC, 0,0,8'h00,12'h000, 1,0,1,8'h10,12'hABC, 0,12'h000, 0,12'h000};
    vecs[1]  = '{1,0,8'h10,12'h000, 0,0,8'h00,12'h000, 1,0,0,8'h10,12'h000, 1,12'hABC, 0,12'h000};
    vecs[2]  = '{1,1,8'h01,12'h111, 0,0,8'h00,12'h000, 1,0,1,8'h01,12'h111, 0,12'h000, 0,12'h000};
    vecs[3]  = '{0,0,8'h00,12'h000, 1,1,8'h02,12'h222, 0,1,1,8'h02,12'h222, 0,12'h000, 0,12'h000};
    for (int i = 4; i < 10; i++) begin
      if (i % 2 == 0)
        vecs[i] = '{1,0,8'h01,12'h000, 1,0,8'h02,12'h000, 1,0,0,8'h01,12'h000, 1,12'h111, 0,12'h000};
      else
        vecs[i] = '{1,0,8'h01,12'h000, 1,0,8'h02,12'h000, 0,1,0,8'h02,12'h000, 0,12'h000, 1,12'h222};
    end
    vecs[10] = '{0,0,8'h00,12'h000, 0,0,8'h00,12'h000, 0,0,0,8'h00,12'h000, 0,12'h000, 0,12'h000};
    vecs[11] = '{1,0,8'h01,12'h000, 0,0,8'h00,12'h000, 1,0,0,8'h01,12'h000, 1,12'h111, 0,12'h000};
    vecs[12] = '{1,0,8'h20,12'h000, 1,1,8'h20,12'h555, 0,1,1,8'h20,12'h555, 0,12'h000, 0,12'h000};
    vecs[13] = '{1,0,8'h20,12'h000, 0,0,8'h00,12'h000, 1,0,0,8'h20,12'h000, 1,12'h555, 0,12'h000};

    // Reset with a read from requester 0 already pending.
    rst_n = 1'b0;
    drive(1, 0, 8'h10, 12'h000, 0, 0, 8'h00, 12'h000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_ready_we", {req1_ready, req0_ready, ram_we}, 3'b000);
    check("rst_regs", {init_done, rsp1_valid, rsp0_valid}, 3'b000);
    check("rst_data", {rsp1_data, rsp0_data}, 24'h0);

    // Fill sequence; the pending read is only accepted on the first RUN cycle.
    run_init(1'b1);
    @(posedge clk);
    #1;
    check("first_rsp0", {rsp0_valid, rsp0_data}, {1'b1, 12'h000});

    // Every word reads back zero, one read per cycle from requester 0.
    for (int a = 0; a < 2**AW; a++) begin
      @(negedge clk);
      drive(1, 0, AW'(a), 12'h000, 0, 0, 8'h00, 12'h000);
      #1;
      check($sformatf("fill_rdy_%0h", a), req0_ready, 1'b1);
      @(posedge clk);
      #1;
      check($sformatf("fill_rd_%0h", a), {rsp0_valid, rsp0_data}, {1'b1, 12'h000});
    end

    for (int i = 0; i < 14; i++) apply(vecs[i], i);

    // Reset mid-RUN while a read response is pending.
    @(negedge clk);
    drive(1, 0, 8'h10, 12'h000, 0, 0, 8'h00, 12'h000);
    @(posedge clk);
    #1;
    check("pre_rst_rsp0", {rsp0_valid, rsp0_data}, {1'b1, 12'hABC});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready_we", {req0_ready, ram_we}, 2'b00);
    @(posedge clk);
    #1;
    check("midrst_regs", {init_done, rsp0_valid, rsp0_data}, {1'b0, 1'b0, 12'h000});
    @(negedge clk);
    drive(0, 0, 8'h00, 12'h000, 0, 0, 8'h00, 12'h000);
    run_init(1'b0);

    @(negedge clk);
    drive(1, 0, 8'h10, 12'h000, 0, 0, 8'h00, 12'h000);
    #1;
    check("post_rst_rdy", req0_ready, 1'b1);
    @(posedge clk);
    #1;
    check("post_rst_rd10", {rsp0_valid, rsp0_data}, {1'b1, 12'h000});
    @(negedge clk);
    drive(0, 0, 8'h00, 12'h000, 0, 0, 8'h00, 12'h000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares one single-port RAM block (synchronous write, asynchronous read, 2^ADDR_W x DATA_W) between two requesters, e.g. the CPU side and the display/scan side.
After reset it runs an init sequence that zero-fills every RAM word, then asserts init_done.
After init it grants at most one access per cycle with round-robin tie-break, and returns read data on a registered response channel.
It sits directly in front of the RAM instance and drives the RAM's address, data and write-enable pins.

Parameters:
ADDR_W, 8, RAM address width; depth = 2^ADDR_W
DATA_W, 12, RAM word width
INIT_VAL, 0 (DATA_W bits), value written to every word during init

Ports:
clk  in  1  single clock; all state on rising edge
rst_n  in  1  synchronous, active-low reset
req0_valid  in  1  requester 0 has an access pending
req0_we  in  1  1 = write, 0 = read
req0_addr  in  ADDR_W  access address
req0_wdata  in  DATA_W  write data
req0_ready  out  1  access accepted this cycle (grant)
rsp0_valid  out  1  read data valid, one-cycle pulse
rsp0_data  out  DATA_W  read data
req1_* / rsp1_*  same set as requester 0, for requester 1
ram_addr  out  ADDR_W  to RAM addr
ram_din  out  DATA_W  to RAM din
ram_we  out  1  to RAM write_en
ram_dout  in  DATA_W  from RAM dout (combinational read)
init_done  out  1  high once zero-fill is complete

Behaviour:
- FSM states: INIT, RUN. rst_n low at a clock edge -> state INIT, init counter 0, last_grant=1, all registered outputs 0.
- Reset outputs: init_done=0, rsp0/1_valid=0, rsp0/1_data=0, last_grant=1 (requester 0 wins the first tie). While rst_n is low, combinational ram_we, req0_ready and req1_ready are forced to 0.
- INIT: ram_we=1, ram_addr=cnt, ram_din=INIT_VAL, ready outputs 0; cnt increments each cycle.
- INIT exit: on the cycle cnt = 2^ADDR_W-1, go to RUN. init_done goes 1 on the next edge. Init takes exactly 2^ADDR_W cycles (256 by default).
- RUN grant (combinational, same cycle):
  - only reqN_valid -> grant N;
  - both valid -> grant the requester that is not last_grant;
  - none valid -> no grant, ram_we=0.
- On a grant: reqN_ready=1, ram_addr=reqN_addr, ram_din=reqN_wdata, ram_we=reqN_we. The other ready stays 0 and its request must be held until accepted.
- last_grant updates to N on every granted cycle. It holds on idle cycles.
- Reads: on the edge ending a granted read, rspN_data<=ram_dout and rspN_valid<=1 for exactly one cycle. Latency is 1 cycle. rspN_data holds its value until the next read response.
- Writes produce no response. A write is committed on the grant edge; a read of the same address on the next cycle returns the new data.
- Back-to-back: one requester alone is granted every cycle (100% throughput). Both continuously valid -> strict alternation.
- A request arriving during INIT waits: ready stays 0 until the first RUN cycle.
- Reset mid-INIT or mid-RUN restarts INIT from address 0. Pending responses are dropped (rsp_valid cleared).

Decomposition:
- Shared package holds: ARB_ADDR_W=8, ARB_DATA_W=12, state encoding (ST_INIT, ST_RUN), and the requester index constants (REQ0, REQ1).
- No sub-module is needed; the RAM stays a sibling instance wired by the parent.
- The round-robin grant logic may be factored as rr_grant2 if reused elsewhere.

Test Plan:
1. Release reset, no requests -> ram_we=1 for exactly 256 cycles with ram_addr 0..255 and ram_din=0; init_done=1 at cycle 257; then reading any of the 256 addresses returns 0.
2. After init: req0 writes 0xABC to 0x10; next cycle req0 reads 0x10 -> req0_ready=1 both cycles; rsp0_valid pulses one cycle after the read with rsp0_data=0xABC.
3. Both requesters hold valid reads for 6 cycles (req0 addr 0x01, req1 addr 0x02) -> grants go 0,1,0,1,0,1; each requester gets 3 responses.
4. req1 write 0x555 to 0x20 and req0 read 0x20 asserted in the same cycle, last_grant=0 -> req1 granted first; req0 granted the next cycle and rsp0_data=0x555.
5. req0_valid asserted during INIT -> req0_ready stays 0 for all 256 init cycles, then goes 1 on the first RUN cycle.
6. rst_n low for one cycle at RUN with a read response pending -> rsp_valid=0; INIT restarts at address 0; the previously written 0xABC at 0x10 reads back as 0 after init.
